seg7_frame_encoder: RTL

Inverse of the keyboard display path's hex-to-segment conversion: snoops a scanned, multiplexed 4-digit seven-segment bus (segment lines plus one-hot digit enables), waits for each digit's pattern to settle, encodes it back to a hex nibble, and publishes a complete 16-bit frame through a valid/ready handshake. It sits beside the display driver so that self-test logic and the host can read back what is actually shown, and it flags any pattern that is not a legal hex glyph.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_glyph_encoder.sv | 30 +++
 rtl/seg7_frame_encoder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared seven-segment definitions: the hex glyph table (also
//               used by the display decoder), the nibble reported for an
//               unrecognised pattern, and the frame encoder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Glyph per hex value, bit order seg[0:7] = a,b,c,d,e,f,g,dp with dp = 0.
  localparam logic [0:7] SEG7_GLYPHS [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E
  };

  // Nibble reported for a pattern that is not a legal glyph.
  localparam logic [3:0] SEG7_ERR_NIBBLE = 4'hE;

  // Frame acquisition states.
  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_ACQ     = 2'd1,
    ST_PUBLISH = 2'd2
  } seg7_state_e;

endpackage
`default_nettype wire

// File: rtl/seg7_glyph_encoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_glyph_encoder
// Description : Combinational reverse lookup of a seven-segment pattern
//               (a..g, dp excluded) into its hex nibble. Patterns that are
//               not in the glyph table give SEG7_ERR_NIBBLE with o_err set.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_glyph_encoder
  import seg7_pkg::*;
(
  input  logic [0:6] i_seg,
  output logic [3:0] o_nibble,
  output logic       o_err
);

  // Table search; glyphs are unique so at most one entry matches.
  always_comb begin
    o_nibble = SEG7_ERR_NIBBLE;
    o_err    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i_seg == SEG7_GLYPHS[i][0:6]) begin
        o_nibble = 4'(i);
        o_err    = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg7_frame_encoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_frame_encoder
// Description : Snoops a multiplexed 4-digit seven-segment bus, waits for each
//               digit to settle, encodes it back to hex and publishes a
//               16-bit frame over a valid/ready handshake with a sticky
//               overrun flag for dropped frames.
//               Optional macro SEG7_DP_CAPTURE_EN: capture the dp segment per
//               digit on dp_out; when undefined dp is ignored and dp_out = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_frame_encoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [0:7]  seg_in,
  input  logic [3:0]  dig_en,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [15:0] value,
  output logic [3:0]  err,
  output logic [3:0]  dp_out,
  output logic        overrun
);

  localparam logic [7:0] c_cap_cnt = 8'(STABLE_CYCLES - 1);

  logic [0:7]  w_seg_m;
  logic        w_changed;
  logic        w_onehot;
  logic [1:0]  w_idx;
  logic        w_stable;
  logic        w_start;
  logic [3:0]  w_nib;
  logic        w_gerr;

  logic [0:7]  r_seg;
  logic [3:0]  r_dig;
  logic [7:0]  r_cnt;

  seg7_state_e r_state;
  logic [1:0]  r_exp;
  logic [1:0]  r_last;
  logic        r_last_vld;
  logic [15:0] r_sh_val;
  logic [3:0]  r_sh_err;
  logic [3:0]  r_sh_dp;

  logic        r_valid;
  logic [15:0] r_out_val;
  logic [3:0]  r_out_err;
  logic [3:0]  r_out_dp;
  logic        r_overrun;

`ifdef SEG7_DP_CAPTURE_EN
  assign w_seg_m = seg_in;
`else
  // dp forced low so it never disturbs the stability compare or dp_out.
  assign w_seg_m = {seg_in[0:6], seg_in[7] & 1'b0};
`endif

  // The counter tracks whether the input register is about to change value.
  assign w_changed = ({w_seg_m, dig_en} != {r_seg, r_dig});

  // Input register and saturating stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= '0;
      r_dig <= '0;
      r_cnt <= '0;
    end else begin
      r_seg <= w_seg_m;
      r_dig <= dig_en;
      if (w_changed)
        r_cnt <= '0;
      else if (r_cnt != 8'hFF)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  // Decode the registered digit enable into one-hot flag and index.
  always_comb begin
    w_onehot = 1'b1;
    w_idx    = 2'd0;
    case (r_dig)
      4'b0001: w_idx = 2'd0;
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_onehot = 1'b0;
    endcase
  end

  assign w_stable = (r_cnt == c_cap_cnt);
  assign w_start  = (r_dig == 4'b0001);

  seg7_glyph_encoder u_enc (
    .i_seg    (r_seg[0:6]),
    .o_nibble (w_nib),
    .o_err    (w_gerr)
  );

  // Acquisition FSM, shadow frame and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_SYNC;
      r_exp      <= 2'd0;
      r_last     <= 2'd0;
      r_last_vld <= 1'b0;
      r_sh_val   <= '0;
      r_sh_err   <= '0;
      r_sh_dp    <= '0;
      r_valid    <= 1'b0;
      r_out_val  <= '0;
      r_out_err  <= '0;
      r_out_dp   <= '0;
      r_overrun  <= 1'b0;
    end else begin
      // A new frame replaces the outputs only if the old one is gone or
      // being accepted on this very edge; otherwise it is dropped.
      if (r_state == ST_PUBLISH) begin
        if (!r_valid || frame_ready) begin
          r_valid   <= 1'b1;
          r_out_val <= r_sh_val;
          r_out_err <= r_sh_err;
          r_out_dp  <= r_sh_dp;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && frame_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        // PUBLISH resynchronises like SYNC so that a digit 0 arriving right
        // behind digit 3 is not missed.
        ST_SYNC, ST_PUBLISH: begin
          r_state    <= ST_SYNC;
          r_exp      <= 2'd0;
          r_last_vld <= 1'b0;
          if (w_start) begin
            r_state <= ST_ACQ;
            if (w_stable) begin
              r_sh_val[3:0] <= w_nib;
              r_sh_err[0]   <= w_gerr;
              r_sh_dp[0]    <= r_seg[7];
              r_exp         <= 2'd1;
              r_last        <= 2'd0;
              r_last_vld    <= 1'b1;
            end
          end
        end

        ST_ACQ: begin
          if (r_dig == 4'b0000) begin
            // blanking between digits is harmless
          end else if (!w_onehot) begin
            r_state  <= ST_SYNC;
            r_sh_val <= '0;
            r_sh_err <= '0;
            r_sh_dp  <= '0;
          end else if (w_idx == r_exp) begin
            if (w_stable) begin
              r_sh_val[{w_idx, 2'b00} +: 4] <= w_nib;
              r_sh_err[w_idx]               <= w_gerr;
              r_sh_dp[w_idx]                <= r_seg[7];
              r_last                        <= w_idx;
              r_last_vld                    <= 1'b1;
              if (w_idx == 2'd3)
                r_state <= ST_PUBLISH;
              else
                r_exp <= r_exp + 2'd1;
            end
          end else if (r_last_vld && (w_idx == r_last)) begin
            // remainder of the dwell of the digit just captured
          end else begin
            r_state  <= ST_SYNC;
            r_sh_val <= '0;
            r_sh_err <= '0;
            r_sh_dp  <= '0;
          end
        end

        default: r_state <= ST_SYNC;
      endcase
    end
  end

  assign frame_valid = r_valid;
  assign value       = r_out_val;
  assign err         = r_out_err;
  assign dp_out      = r_out_dp;
  assign overrun     = r_overrun;

endmodule
`default_nettype wire
